prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_byte_packer.sv | 37 +++
 rtl/prog_loader.sv | 112 +++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Optional checksum stage is enabled with PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int MAX_WORDS_DEF  = 32768;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word assembler; word/word_vld are valid in the
// same cycle the last byte of a word is presented.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_vld
);

    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0] cnt;
    logic [23:0]   lo;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            lo  <= '0;
        end else if (clr) begin
            cnt <= '0;
            lo  <= '0;
        end else if (byte_vld) begin
            cnt <= cnt + 1'b1;
            // shift right so the first byte lands in bits 7:0 after three more
            lo  <= {byte_in, lo[23:8]};
        end
    end

    assign word     = {byte_in, lo};
    assign word_vld = byte_vld && (cnt == CW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Program loader: byte stream (length, words, optional XOR checksum) written
// into instruction memory. Checksum stage enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        we,
    output logic        io_sel,
    output logic [31:0] addr_io,
    output logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t      state, state_nx;
    logic        launch, take;
    logic [31:0] pk_word;
    logic        pk_vld;
    logic [31:0] word_cnt, word_idx;

    assign launch = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign take   = rx_valid && (state == S_LEN || state == S_DATA);

    byte_packer u_packer (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (launch),
        .byte_vld (take),
        .byte_in  (rx_data),
        .word     (pk_word),
        .word_vld (pk_vld)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       csum <= '0;
        else if (launch) csum <= '0;
        else if (take)   csum <= csum ^ rx_data;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nx = S_LEN;
            S_LEN: begin
                if (pk_vld) begin
                    if (pk_word == 32'd0)    state_nx = S_FIN;
                    else if (pk_word > MAX_W) state_nx = S_ERROR;
                    else                      state_nx = S_DATA;
                end
            end
            S_DATA: if (pk_vld && (word_idx == word_cnt - 32'd1)) state_nx = S_FIN;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: if (rx_valid) state_nx = (rx_data == csum) ? S_DONE : S_ERROR;
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // write port is registered: one-cycle pulse the cycle after a word completes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_cnt <= '0;
            word_idx <= '0;
            we       <= 1'b0;
            addr_io  <= '0;
            din      <= '0;
        end else begin
            we <= 1'b0;
            if (launch) begin
                word_cnt <= '0;
                word_idx <= '0;
            end else if (pk_vld && state == S_LEN) begin
                word_cnt <= pk_word;
            end else if (pk_vld && state == S_DATA) begin
                we       <= 1'b1;
                addr_io  <= ADDR_BASE + (word_idx << 2);
                din      <= pk_word;
                word_idx <= word_idx + 32'd1;
            end
        end
    end

    assign busy   = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
    assign done   = (state == S_DONE);
    assign err    = (state == S_ERROR);
    assign io_sel = busy || we;

endmodule
